// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared DES constants and helpers for des_decrypt_core.
//                Holds the IP/FP/E/P/PC1/PC2 index tables (1-based DES bit
//                numbers, bit 1 = MSB), the key rotation schedules, the FSM
//                state enum and the eight S-box tables.
//                Vectors are stored [N-1:0], so DES bit k of an N-bit value
//                lives at index N-k.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Parity bits 8,16,..,64 never appear here, so they are dropped.
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Decrypt: right rotation applied after round cnt. The final entry is
    // zero because nothing follows the last round.
    localparam logic [1:0] DEC_RSH [16] = '{
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
    };

    // Encrypt: left rotation applied before the subkey of round cnt is used.
    localparam logic [1:0] ENC_LSH [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Each box packs 4 rows x 16 columns of nibbles; entry (row*16+col)
    // sits at bits [255-4*idx -: 4].
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[32-E_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[31-i] = x[32-P_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
        return o;
    endfunction

    // Row is formed from the outer bits (1,6), column from bits 2..5, so the
    // flat table index is simply {b1, b6, b2..b5}.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] six);
        logic [5:0] idx;
        idx = {six[5], six[0], six[4:1]};
        return SBOX_T[box][255 - 4*int'(idx) -: 4];
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[26:0], v[27]};
            2'd2:    return {v[25:0], v[27:26]};
            default: return v;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[0], v[27:1]};
            2'd2:    return {v[1:0], v[27:2]};
            default: return v;
        endcase
    endfunction

    // C (upper 28 bits) and D (lower 28 bits) rotate independently.
    function automatic logic [55:0] rot_cd_left(input logic [55:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] rot_cd_right(input logic [55:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_f_function.sv
`default_nettype none
// ============================================================================
//  Module      : des_f_function
//  Description : Combinational DES round function f(R, K):
//                E-expansion, XOR with subkey, eight S-boxes, P permutation.
//  Ports       : r_i      [31:0] right half (DES bit 1 = MSB)
//                subkey_i [47:0] round subkey
//                f_o      [31:0] f(R, K)
//  Revision    : 1.0 - initial release
// ============================================================================
module des_f_function (
    input  logic [31:0] r_i,
    input  logic [47:0] subkey_i,
    output logic [31:0] f_o
);
    import des_pkg::*;

    logic [47:0] mixed;
    logic [31:0] sbox_out;

    assign mixed = perm_e(r_i) ^ subkey_i;

    // Box g consumes 6-bit group g (bits 6g+1..6g+6) and yields nibble g.
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        logic [5:0] six;
        assign six = mixed[47-6*g -: 6];
        assign sbox_out[31-4*g -: 4] = sbox_lookup(g, six);
    end

    assign f_o = perm_p(sbox_out);

endmodule
`default_nettype wire

// File: rtl/des_decrypt_core.sv
`default_nettype none
// ============================================================================
//  Module      : des_decrypt_core
//  Description : Iterative DES engine, one round per clock. Default build
//                decrypts (subkeys K16..K1). Defining DES_ENCRYPT_MODE_EN adds
//                in_encrypt_i, sampled on accept, selecting encryption
//                (subkeys K1..K16); latency is the same in both modes.
//  Ports       : clk, rst        clock, asynchronous active-high reset
//                in_valid_i      block + key presented
//                in_encrypt_i    1 = encrypt (DES_ENCRYPT_MODE_EN only)
//                in_ready_o      high only while idle
//                in_data_i[63:0] ciphertext (DES bit 1 = bit 63)
//                in_key_i [63:0] key, parity bits ignored
//                out_valid_o     result present, held until out_ready_i
//                out_ready_i     downstream accepts result
//                out_data_o      plaintext, retained while idle
//                busy_o          high while rounds run or result waits
//  Revision    : 1.0 - initial release
// ============================================================================
module des_decrypt_core #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
`ifdef DES_ENCRYPT_MODE_EN
    input  logic        in_encrypt_i,
`endif
    output logic        in_ready_o,
    input  logic [63:0] in_data_i,
    input  logic [63:0] in_key_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_data_o,
    output logic        busy_o
);
    import des_pkg::*;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] l_q;
    logic [31:0] r_q;
    logic [55:0] cd_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [63:0] out_data_q;
`ifdef DES_ENCRYPT_MODE_EN
    logic        enc_q;
`endif

    logic        accept;
    logic [63:0] ip_blk;
    logic [55:0] cd_load;
    logic [55:0] cd_use;
    logic [55:0] cd_d;
    logic [47:0] subkey;
    logic [31:0] f_val;
    logic [31:0] r_d;
    logic [63:0] out_data_d;

    // in_ready_q is high exactly in the idle state.
    assign accept  = in_valid_i & in_ready_q;
    assign ip_blk  = perm_ip(in_data_i);
    assign cd_load = perm_pc1(in_key_i);

    // Decrypt uses the current C/D and rotates right afterwards; the very
    // first round therefore sees C0D0, which equals C16D16 (K16).
    // Encrypt rotates left first and uses the rotated value.
    always_comb begin
        cd_use = cd_q;
        cd_d   = rot_cd_right(cd_q, DEC_RSH[cnt_q]);
`ifdef DES_ENCRYPT_MODE_EN
        if (enc_q) begin
            cd_use = rot_cd_left(cd_q, ENC_LSH[cnt_q]);
            cd_d   = cd_use;
        end
`endif
    end

    assign subkey = perm_pc2(cd_use);

    des_f_function u_f_function (
        .r_i      (r_q),
        .subkey_i (subkey),
        .f_o      (f_val)
    );

    assign r_d = l_q ^ f_val;

    // Result of the last round taken directly from next-state values;
    // {R16, L16} undoes the swap of the final round.
    assign out_data_d = perm_fp({r_d, r_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            l_q         <= '0;
            r_q         <= '0;
            cd_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
`ifdef DES_ENCRYPT_MODE_EN
            enc_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        l_q        <= ip_blk[63:32];
                        r_q        <= ip_blk[31:0];
                        cd_q       <= cd_load;
                        cnt_q      <= 4'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ROUND;
`ifdef DES_ENCRYPT_MODE_EN
                        enc_q      <= in_encrypt_i;
`endif
                    end
                end
                ST_ROUND: begin
                    l_q   <= r_q;
                    r_q   <= r_d;
                    cd_q  <= cd_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(ROUNDS - 1)) begin
                        out_data_q  <= out_data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_decrypt_core
//  Description : Self-checking bench for des_decrypt_core. A behavioural DES
//                model (full key schedule, textbook round loop) plus a
//                cycle-level handshake model is compared against the DUT on
//                every falling edge; known-answer vectors pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_decrypt_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_encrypt = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] in_key = '0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [63:0] out_data_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    des_decrypt_core #(.ROUNDS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
`ifdef DES_ENCRYPT_MODE_EN
        .in_encrypt_i(in_encrypt),
`endif
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data),
        .in_key_i    (in_key),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o)
    );

    // ---------------- reference DES ----------------
    localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int PP [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int LS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // f: expansion group g takes bits 4g..4g+5 (wrapping 0->32, 33->1).
    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [31:0] s, o;
        logic [5:0]  six;
        int          n, idx;
        s = '0;
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < 6; j++) begin
                n = ((4*g - 1 + j + 32) % 32) + 1;
                six[5-j] = r[32-n];
            end
            six = six ^ k[47-6*g -: 6];
            idx = 16*int'({six[5], six[0]}) + int'(six[4:1]);
            s[31-4*g -: 4] = SB[g][255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-PP[i]];
        return o;
    endfunction

    function automatic logic [63:0] m_des(input logic [63:0] blk, input logic [63:0] key,
                                          input logic enc);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks [16];
        logic [63:0] x, y, o;
        logic [31:0] l, r, t;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int s = 0; s < LS[rd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-PC2[i]];
        end
        for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP[i]];
        l = x[63:32];
        r = x[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            t = r;
            r = l ^ m_f(r, enc ? ks[rd] : ks[15-rd]);
            l = t;
        end
        y = {r, l};
        // Final permutation is the inverse of IP.
        for (int i = 0; i < 64; i++) o[64-IP[i]] = y[63-i];
        return o;
    endfunction

    // ---------------- handshake model ----------------
    int          m_timer = 0;   // rounds left before the result appears
    logic        m_valid = 1'b0;
    logic [63:0] m_out = '0;
    logic [63:0] m_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_timer = 0;
            m_valid = 1'b0;
            m_out   = '0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_timer != 0) begin
            m_timer = m_timer - 1;
            if (m_timer == 0) begin
                m_valid = 1'b1;
                m_out   = m_res;
            end
        end else if (in_valid) begin
            m_res   = m_des(in_data, in_key, in_encrypt);
            m_timer = 16;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_timer != 0) || m_valid;
        if (!rst) chk("cyc_in_ready", {63'd0, in_ready_o}, {63'd0, !m_busy});
        chk("cyc_out_valid", {63'd0, out_valid_o}, {63'd0, m_valid});
        chk("cyc_busy", {63'd0, busy_o}, {63'd0, m_busy});
        chk("cyc_out_data", out_data_o, m_out);
    end

    // DUT accept counter (sampled mid-cycle, before the deciding edge)
    int dut_accepts = 0;
    always @(negedge clk) if (!rst && in_valid && in_ready_o) dut_accepts++;

    // ---------------- directed helpers ----------------
    task automatic send(input logic [63:0] d, input logic [63:0] k, input logic e,
                        output bit ok);
        in_data = d; in_key = k; in_encrypt = e; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready_o) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_block(input string nm, input logic [63:0] d, input logic [63:0] k,
                             input logic e, input logic [63:0] exp, input int hold);
        bit ok, got;
        int lat;
        send(d, k, e, ok);
        if (ok) begin
            lat = 0; got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                lat++;
                if (out_valid_o) begin got = 1'b1; break; end
            end
            if (!got) chk({nm, "_out_timeout"}, 64'd0, 64'd1);
            else begin
                chk({nm, "_latency"}, 64'(lat), 64'd16);
                chk(nm, out_data_o, exp);
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    chk({nm, "_hold_valid"}, {63'd0, out_valid_o}, 64'd1);
                    chk({nm, "_hold_data"}, out_data_o, exp);
                    chk({nm, "_hold_in_ready"}, {63'd0, in_ready_o}, 64'd0);
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                chk({nm, "_valid_drop"}, {63'd0, out_valid_o}, 64'd0);
                chk({nm, "_data_kept"}, out_data_o, exp);
            end
        end
    endtask

    initial begin
        bit ok;
        int acc0;

        // model pinned by known answers
        chk("model_kat1", m_des(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0),
            64'h0123456789ABCDEF);
        chk("model_kat2", m_des(64'h0, 64'h0E329232EA6D0D73, 1'b0), 64'h8787878787878787);
        chk("model_enc", m_des(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1),
            64'h85E813540F0AB405);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_out_data", out_data_o, 64'd0);

        run_block("kat1", 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0,
                  64'h0123456789ABCDEF, 10);
        run_block("kat2", 64'h0, 64'h0E329232EA6D0D73, 1'b0, 64'h8787878787878787, 0);

        // abort in the middle of the rounds
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, ok);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_out_data", out_data_o, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready_o}, 64'd1);
        repeat (20) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {63'd0, out_valid_o}, 64'd0);
        end
        run_block("after_abort", 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0,
                  64'h0123456789ABCDEF, 2);

        // back-to-back, inputs changing every cycle while busy
        acc0 = dut_accepts;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            in_data = {$urandom, $urandom};
            in_key  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 64'(dut_accepts - acc0), 64'd3);
        repeat (20) @(posedge clk);
        #1;

        // random traffic
        for (int c = 0; c < 700; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            in_key    = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef DES_ENCRYPT_MODE_EN
            in_encrypt = 1'($urandom_range(0, 1));
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_encrypt = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1 out_ready = 1'b0;

`ifdef DES_ENCRYPT_MODE_EN
        run_block("enc_kat", 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1,
                  64'h85E813540F0AB405, 1);
        run_block("dec_after_enc", 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0,
                  64'h0123456789ABCDEF, 0);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
